// File: rtl/stream_xbar_router_pkg.sv
// Shared widths, cfg packing helpers and FSM encoding for the stream crossbar.
// Pure definitions: no latency, no backpressure.
package stream_xbar_router_pkg;

  function automatic int sel_width(input int n_inputs);
    return (n_inputs > 1) ? $clog2(n_inputs) : 1;
  endfunction

  // Each output's cfg field is {en, sel}, so one bit wider than the select.
  function automatic int cfg_width(input int n_inputs);
    return sel_width(n_inputs) + 1;
  endfunction

  typedef logic state_t;
  localparam state_t RUN   = 1'b0;
  localparam state_t DRAIN = 1'b1;

endpackage

// File: rtl/stream_xbar_fifo.sv
// Per-output circular buffer; head visible 1 cycle after push.
// Backpressure: full is a pure occupancy flag, push while full is dropped.
module stream_xbar_fifo #(
  parameter int BIT_WIDTH = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [BIT_WIDTH-1:0] push_dat,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [BIT_WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [BIT_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(BUF_DEPTH));
  assign empty   = (count == '0);
  // Gate the head so stale storage never reaches send_msg.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/stream_xbar_router.sv
// N x M val/rdy crossbar with per-output FIFOs, multicast and drain-then-apply cfg.
// Latency 1 cycle; an input is ready only when every output it feeds has room.
module stream_xbar_router
  import stream_xbar_router_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_INPUTS  = 2,
  parameter int N_OUTPUTS = 2,
  parameter int BUF_DEPTH = 2,
  localparam int SEL_W    = sel_width(N_INPUTS),
  localparam int CFG_W    = SEL_W + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_INPUTS*BIT_WIDTH-1:0]  recv_msg,
  input  logic [N_INPUTS-1:0]            recv_val,
  output logic [N_INPUTS-1:0]            recv_rdy,
  output logic [N_OUTPUTS*BIT_WIDTH-1:0] send_msg,
  output logic [N_OUTPUTS-1:0]           send_val,
  input  logic [N_OUTPUTS-1:0]           send_rdy,
  input  logic [N_OUTPUTS*CFG_W-1:0]     control,
  input  logic                           control_val,
  output logic                           control_rdy,
  output logic [N_OUTPUTS*CFG_W-1:0]     cfg_o,
  output logic                           busy
);

  state_t                             state;
  state_t                             state_nxt;
  logic [N_OUTPUTS*CFG_W-1:0]         cfg;
  logic [N_OUTPUTS*CFG_W-1:0]         pending;
  logic [N_OUTPUTS-1:0]               fifo_full;
  logic [N_OUTPUTS-1:0]               fifo_empty;
  logic [N_OUTPUTS-1:0]               push;
  logic [N_OUTPUTS-1:0][BIT_WIDTH-1:0] push_dat;
  logic [N_OUTPUTS-1:0]               route_en;
  logic [N_OUTPUTS-1:0][SEL_W-1:0]    route_sel;
  logic [N_INPUTS-1:0][N_OUTPUTS-1:0] routed;
  logic                               all_empty;
  logic                               accept;
  logic                               apply;

  // An out-of-range select matches no input, so that output stays idle.
  always_comb begin
    for (int o = 0; o < N_OUTPUTS; o++) begin
      route_en[o]  = cfg[o*CFG_W + SEL_W];
      route_sel[o] = cfg[o*CFG_W +: SEL_W];
    end
    for (int i = 0; i < N_INPUTS; i++) begin
      for (int o = 0; o < N_OUTPUTS; o++) begin
        routed[i][o] = route_en[o] && (route_sel[o] == SEL_W'(i));
      end
    end
  end

  // Fullness only: no combinational path from send_rdy back to recv_rdy.
  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      recv_rdy[i] = (state == RUN) && (|routed[i]) && ((routed[i] & fifo_full) == '0);
    end
  end

  always_comb begin
    push     = '0;
    push_dat = '0;
    for (int o = 0; o < N_OUTPUTS; o++) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (routed[i][o] && recv_val[i] && recv_rdy[i]) begin
          push[o]     = 1'b1;
          push_dat[o] = recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

  for (genvar o = 0; o < N_OUTPUTS; o++) begin : g_out
    stream_xbar_fifo #(
      .BIT_WIDTH (BIT_WIDTH),
      .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[o]),
      .push_dat (push_dat[o]),
      .pop      (send_rdy[o]),
      .full     (fifo_full[o]),
      .empty    (fifo_empty[o]),
      .head     (send_msg[o*BIT_WIDTH +: BIT_WIDTH])
    );
    assign send_val[o] = !fifo_empty[o];
  end

  assign all_empty = &fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (control_val) state_nxt = DRAIN;
      DRAIN:   if (all_empty)   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    control_rdy = (state == RUN);
    busy        = (state == DRAIN);
    accept      = control_rdy && control_val;
    apply       = busy && all_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg     <= '0;
      pending <= '0;
    end else begin
      if (accept) pending <= control;
      if (apply)  cfg     <= pending;
    end
  end

  assign cfg_o = cfg;

endmodule

// File: tb/tb_stream_xbar_router.sv
// Randomised + directed bench for stream_xbar_router (3 inputs, 2 outputs).
// A queue-based reference model predicts outputs; a monitor scoreboards delivered words.
module tb_stream_xbar_router;

  localparam int BW = 32;
  localparam int NI = 3;
  localparam int NO = 2;
  localparam int BD = 2;
  localparam int SW = 2;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NI*BW-1:0]  recv_msg;
  logic [NI-1:0]     recv_val;
  logic [NI-1:0]     recv_rdy;
  logic [NO*BW-1:0]  send_msg;
  logic [NO-1:0]     send_val;
  logic [NO-1:0]     send_rdy;
  logic [NO*CW-1:0]  control;
  logic              control_val;
  logic              control_rdy;
  logic [NO*CW-1:0]  cfg_o;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_xbar_router #(
    .BIT_WIDTH (BW),
    .N_INPUTS  (NI),
    .N_OUTPUTS (NO),
    .BUF_DEPTH (BD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .recv_msg    (recv_msg),
    .recv_val    (recv_val),
    .recv_rdy    (recv_rdy),
    .send_msg    (send_msg),
    .send_val    (send_val),
    .send_rdy    (send_rdy),
    .control     (control),
    .control_val (control_val),
    .control_rdy (control_rdy),
    .cfg_o       (cfg_o),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-output expected-word queues and occupancy counts.
  typedef logic [BW-1:0] word_q_t[$];
  word_q_t          exp_q [NO];
  int               occ   [NO];
  logic             m_run;
  logic [NO*CW-1:0] m_cfg;
  logic [NO*CW-1:0] m_pend;
  logic [NI-1:0]    e_rdy;
  logic [NO-1:0]    e_val;
  logic [NO-1:0]    e_push;
  logic [NO-1:0]    e_pop;
  bit               any_r;
  bit               ok_r;
  bit               empty_all;

  function automatic bit m_routed(input int i, input int o);
    logic [CW-1:0] f;
    f = m_cfg[o*CW +: CW];
    return f[CW-1] && (int'(f[SW-1:0]) == i);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_send_val", send_val, '0);
      chk("rst_recv_rdy", recv_rdy, '0);
      chk("rst_control_rdy", control_rdy, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cfg_o", cfg_o, '0);
      chk("rst_send_msg", send_msg, '0);
      for (int o = 0; o < NO; o++) begin
        exp_q[o].delete();
        occ[o] = 0;
      end
      m_run  = 1'b1;
      m_cfg  = '0;
      m_pend = '0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        any_r = 1'b0;
        ok_r  = 1'b1;
        for (int o = 0; o < NO; o++) begin
          if (m_routed(i, o)) begin
            any_r = 1'b1;
            if (occ[o] >= BD) ok_r = 1'b0;
          end
        end
        e_rdy[i] = m_run && any_r && ok_r;
      end
      for (int o = 0; o < NO; o++) e_val[o] = (occ[o] > 0);
      chk("send_val", send_val, e_val);
      chk("recv_rdy", recv_rdy, e_rdy);
      chk("control_rdy", control_rdy, m_run);
      chk("busy", busy, !m_run);
      chk("cfg_o", cfg_o, m_cfg);
      e_push = '0;
      for (int i = 0; i < NI; i++) begin
        if (recv_val[i] && e_rdy[i]) begin
          for (int o = 0; o < NO; o++) begin
            if (m_routed(i, o)) begin
              exp_q[o].push_back(recv_msg[i*BW +: BW]);
              e_push[o] = 1'b1;
            end
          end
        end
      end
      empty_all = 1'b1;
      for (int o = 0; o < NO; o++) begin
        if (occ[o] != 0) empty_all = 1'b0;
        e_pop[o] = e_val[o] && send_rdy[o];
        occ[o]   = occ[o] + int'(e_push[o]) - int'(e_pop[o]);
      end
      if (m_run && control_val) begin
        m_pend = control;
        m_run  = 1'b0;
      end else if (!m_run && empty_all) begin
        m_cfg = m_pend;
        m_run = 1'b1;
      end
    end
  end

  // Monitor: every delivered word must be the oldest expected word for that output.
  always @(negedge clk) begin
    if (reset) begin
      for (int o = 0; o < NO; o++) begin
        if (send_val[o] && send_rdy[o]) begin
          if (exp_q[o].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow out%0d: got %0h expected nothing", o, send_msg[o*BW +: BW]);
          end else begin
            chk($sformatf("send_msg%0d", o), send_msg[o*BW +: BW], exp_q[o].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NO*CW-1:0] mk(input bit en1, input int sel1, input bit en0, input int sel0);
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    a = {en1, SW'(sel1)};
    b = {en0, SW'(sel0)};
    return {a, b};
  endfunction

  task automatic apply_cfg(input logic [NO*CW-1:0] c);
    for (int n = 0; n < 50 && !control_rdy; n++) tick();
    control     = c;
    control_val = 1'b1;
    tick();
    control_val = 1'b0;
    for (int n = 0; n < 50 && busy; n++) tick();
    chk("cfg_applied", cfg_o, c);
  endtask

  initial begin
    int acc;
    logic [NO*CW-1:0] new_cfg;
    reset       = 1'b0;
    recv_val    = '0;
    recv_msg    = '0;
    send_rdy    = '0;
    control     = '0;
    control_val = 1'b0;

    // Reset held with inputs asserted
    recv_val = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_rdy", recv_rdy, '0);
    chk("rst_hold_val", send_val, '0);
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_rdy", recv_rdy, '0);
    chk("post_rst_val", send_val, '0);
    chk("post_rst_crdy", control_rdy, 1'b1);
    chk("post_rst_cfg", cfg_o, '0);
    recv_val = '0;

    // Unicast, checking the minimum accept-to-apply delay on the way
    control     = mk(1, 0, 1, 1);
    control_val = 1'b1;
    tick();
    control_val = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_cfg_old", cfg_o, '0);
    tick();
    chk("apply_2edges", cfg_o, mk(1, 0, 1, 1));
    chk("apply_busy", busy, 1'b0);
    recv_msg = {32'h0, 32'hDEADBEEF, 32'h12345678};
    recv_val = 3'b011;
    tick();
    recv_val = '0;
    chk("uc_send_val", send_val, 2'b11);
    chk("uc_out0", send_msg[BW-1:0], 32'hDEADBEEF);
    chk("uc_out1", send_msg[2*BW-1:BW], 32'h12345678);
    send_rdy = '1;
    tick();
    tick();
    chk("uc_drained", send_val, '0);

    // Multicast with one stalled output
    apply_cfg(mk(1, 0, 1, 0));
    send_rdy = 2'b01;
    acc = 0;
    for (int w = 1; w <= 3; w++) begin
      recv_msg[BW-1:0] = BW'(w);
      recv_val = 3'b001;
      for (int n = 0; n < 6 && !recv_rdy[0]; n++) tick();
      if (!recv_rdy[0]) break;
      tick();
      acc++;
    end
    chk("mc_accepts", acc, 2);
    chk("mc_stall_rdy", recv_rdy[0], 1'b0);
    send_rdy = 2'b11;
    for (int n = 0; n < 6 && !recv_rdy[0]; n++) tick();
    if (recv_rdy[0]) begin
      tick();
      acc++;
    end
    recv_val = '0;
    chk("mc_accepts_after", acc, 3);
    repeat (4) tick();
    chk("mc_drained", send_val, '0);

    // Reconfiguration waits for the buffered words to drain
    apply_cfg(mk(0, 0, 1, 0));
    send_rdy = '0;
    recv_msg[BW-1:0] = 32'hA1;
    recv_val = 3'b001;
    tick();
    recv_msg[BW-1:0] = 32'hA2;
    tick();
    recv_val = '0;
    new_cfg     = mk(1, 1, 1, 2);
    control     = new_cfg;
    control_val = 1'b1;
    tick();
    control_val = 1'b0;
    recv_val    = '1;
    chk("drain_busy", busy, 1'b1);
    chk("drain_rdy", recv_rdy, '0);
    chk("drain_crdy", control_rdy, 1'b0);
    chk("drain_cfg_old", cfg_o, mk(0, 0, 1, 0));
    send_rdy = 2'b01;
    tick();
    tick();
    chk("drain_not_yet", cfg_o, mk(0, 0, 1, 0));
    chk("drain_busy2", busy, 1'b1);
    tick();
    chk("drain_applied", cfg_o, new_cfg);
    chk("drain_done", busy, 1'b0);
    chk("drain_crdy2", control_rdy, 1'b1);
    chk("drain_new_rdy", recv_rdy, 3'b110);
    recv_val = '0;
    send_rdy = '1;
    tick();

    // Out-of-range select leaves output 0 dead
    apply_cfg(mk(1, 2, 1, 3));
    send_rdy = '1;
    recv_val = '1;
    for (int c = 0; c < 8; c++) begin
      recv_msg = {$urandom, $urandom, $urandom};
      tick();
      chk("inv_send_val0", send_val[0], 1'b0);
      chk("inv_rdy", recv_rdy, 3'b100);
    end
    recv_val = '0;
    repeat (3) tick();

    // Asynchronous reset between edges while data is buffered
    apply_cfg(mk(1, 1, 1, 0));
    send_rdy = '0;
    recv_msg = {32'h0, 32'hB0B0B0B0, 32'hC0C0C0C0};
    recv_val = 3'b011;
    tick();
    recv_val = '0;
    tick();
    chk("pre_rst_val", send_val, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    chk("async_send_val", send_val, '0);
    chk("async_cfg_o", cfg_o, '0);
    chk("async_send_msg", send_msg, '0);
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    send_rdy = '1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("no_stale", send_val, '0);
    end

    // Random traffic with occasional reconfiguration
    for (int c = 0; c < 3000; c++) begin
      recv_val = NI'($urandom);
      recv_msg = {$urandom, $urandom, $urandom};
      for (int o = 0; o < NO; o++) send_rdy[o] = ($urandom_range(0, 3) != 0);
      control_val = ($urandom_range(0, 19) == 0);
      control     = (NO*CW)'($urandom);
      tick();
    end
    control_val = 1'b0;
    recv_val    = '0;
    send_rdy    = '1;
    repeat (10) tick();
    chk("final_q0", exp_q[0].size(), 0);
    chk("final_q1", exp_q[1].size(), 0);
    chk("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
